// File: rtl/div_iter.sv
// Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; divide-by-zero and signed overflow complete in one cycle.
module div_iter #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2:0]            div_ctrl,
    input  logic [DATA_WIDTH-1:0] op1,
    input  logic [DATA_WIDTH-1:0] op2,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  busy,
    output logic                  div_ready
);

    localparam int unsigned DW    = DATA_WIDTH;
    localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
    localparam logic [DW-1:0] MIN_NEG  = {1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0] ALL_ONES = {DW{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIXUP,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [1:0]         r_ctrl;
    logic [DW-1:0]      r_dividend;
    logic [DW-1:0]      r_divisor;
    logic [DW-1:0]      r_rem;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_q_neg;
    logic               r_r_neg;
    logic [DW-1:0]      r_result;

    logic               w_accept;
    logic               w_fixup_wr;
    logic               w_signed;
    logic               w_div_zero;
    logic               w_ovf;
    logic               w_special;
    logic [DW-1:0]      w_special_res;
    logic [DW-1:0]      w_abs1;
    logic [DW-1:0]      w_abs2;
    logic [DW:0]        w_shift;
    logic [DW:0]        w_diff;
    logic               w_borrow;
    logic [DW-1:0]      w_rem_nxt;
    logic [DW-1:0]      w_quot_nxt;
    logic [DW-1:0]      w_q_fix;
    logic [DW-1:0]      w_r_fix;
    logic [1:0]         w_unused;

    // Request decode: special cases bypass the iteration entirely
    assign w_signed      = ~div_ctrl[0];
    assign w_div_zero    = (op2 == '0);
    assign w_ovf         = w_signed && (op1 == MIN_NEG) && (op2 == ALL_ONES);
    assign w_special     = w_div_zero || w_ovf;
    assign w_special_res = div_ctrl[1] ? (w_div_zero ? op1 : '0)
                                       : (w_div_zero ? ALL_ONES : MIN_NEG);
    assign w_abs1        = (w_signed && op1[DW-1]) ? -op1 : op1;
    assign w_abs2        = (w_signed && op2[DW-1]) ? -op2 : op2;

    // Restoring step: the borrow of the widened subtraction decides restore vs keep
    assign w_shift               = {r_rem, r_dividend[DW-1]};
    assign {w_borrow, w_diff}    = {1'b0, w_shift} - {2'b00, r_divisor};
    assign w_rem_nxt             = w_borrow ? w_shift[DW-1:0] : w_diff[DW-1:0];
    assign w_quot_nxt            = {r_dividend[DW-2:0], ~w_borrow};
    // A kept difference is always below the divisor, so its top bit is never needed
    assign w_unused              = {div_ctrl[2], w_diff[DW]};

    assign w_q_fix = (~r_ctrl[0] && r_q_neg) ? -r_dividend : r_dividend;
    assign w_r_fix = (~r_ctrl[0] && r_r_neg) ? -r_rem : r_rem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_fixup_wr  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && !flush) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_special ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (flush) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == '0) begin
                    w_state_nxt = S_FIXUP;
                end
            end
            S_FIXUP: begin
                if (flush) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_fixup_wr  = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath registers; result is only written at accept (special) or FIXUP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl     <= '0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_rem      <= '0;
            r_cnt      <= '0;
            r_q_neg    <= 1'b0;
            r_r_neg    <= 1'b0;
            r_result   <= '0;
        end else if (w_accept) begin
            r_ctrl     <= div_ctrl[1:0];
            r_dividend <= w_abs1;
            r_divisor  <= w_abs2;
            r_rem      <= '0;
            r_cnt      <= CNT_W'(DW - 1);
            r_q_neg    <= op1[DW-1] ^ op2[DW-1];
            r_r_neg    <= op1[DW-1];
            if (w_special) begin
                r_result <= w_special_res;
            end
        end else if (r_state == S_CALC) begin
            r_rem      <= w_rem_nxt;
            r_dividend <= w_quot_nxt;
            r_cnt      <= r_cnt - CNT_W'(1);
        end else if (w_fixup_wr) begin
            r_result <= r_ctrl[1] ? w_r_fix : w_q_fix;
        end
    end

    assign result    = r_result;
    assign busy      = (r_state != S_IDLE);
    assign div_ready = (r_state == S_DONE);

endmodule

// File: tb/tb_div_iter.sv
// Randomized and directed bench for div_iter against an arithmetic reference model.
module tb_div_iter;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  div_ctrl;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        flush;
    logic [31:0] result;
    logic        busy;
    logic        div_ready;

    int n_vec = 0;
    int n_err = 0;

    div_iter #(.DATA_WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .div_ctrl  (div_ctrl),
        .op1       (op1),
        .op2       (op2),
        .flush     (flush),
        .result    (result),
        .busy      (busy),
        .div_ready (div_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic bit is_special(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'h0) || (!c[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // RISC-V M-extension semantics from plain arithmetic
    function automatic logic [31:0] ref_div(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (b == 32'h0) return c[1] ? a : 32'hFFFF_FFFF;
        if (!c[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return c[1] ? 32'h0 : 32'h8000_0000;
        if (!c[0]) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'h0, a});
            sb = longint'({32'h0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return c[1] ? r[31:0] : q[31:0];
    endfunction

    // Called #1 after the accepting edge; lat counts cycles from that edge
    task automatic wait_ready(output int lat);
        lat = 1;
        while (!div_ready && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic launch(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start    = 1'b1;
        div_ctrl = c;
        op1      = a;
        op2      = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        div_ctrl = 3'(4 + $urandom_range(0, 3));
        op1      = $urandom;
        op2      = $urandom;
    endtask

    task automatic run_op(input string tag, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp;
        int          exp_lat;
        int          lat;
        exp     = ref_div(c, a, b);
        exp_lat = is_special(c, a, b) ? 1 : 34;
        launch(c, a, b);
        if (exp_lat > 1) chk({tag, " busy_calc"}, 32'(busy), 32'd1);
        wait_ready(lat);
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " result"}, result, exp);
        chk({tag, " busy_done"}, 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        chk({tag, " ready_drop"}, 32'(div_ready), 32'd0);
        chk({tag, " idle"}, 32'(busy), 32'd0);
        chk({tag, " hold"}, result, exp);
    endtask

    task automatic count_pulses(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (div_ready) pulses++;
        end
    endtask

    initial begin
        logic [31:0] held;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  c;
        int          lat;
        int          pulses;

        rst_n    = 1'b0;
        start    = 1'b0;
        flush    = 1'b0;
        div_ctrl = 3'b100;
        op1      = '0;
        op2      = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset result", result, 32'h0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset ready", 32'(div_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("divu 100/7", 3'b101, 32'd100, 32'd7);
        run_op("remu 100/7", 3'b111, 32'd100, 32'd7);
        run_op("div -7/2",   3'b100, 32'hFFFF_FFF9, 32'd2);
        run_op("rem -7/2",   3'b110, 32'hFFFF_FFF9, 32'd2);
        run_op("rem 7/-2",   3'b110, 32'd7, 32'hFFFF_FFFE);
        run_op("div 5/0",    3'b100, 32'd5, 32'd0);
        run_op("remu 5/0",   3'b111, 32'd5, 32'd0);
        run_op("div ovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("rem ovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("divu min/-1", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("div min/2",  3'b100, 32'h8000_0000, 32'd2);

        // Flush in the tenth CALC cycle
        held = result;
        launch(3'b101, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush calc idle", 32'(busy), 32'd0);
        count_pulses(40, pulses);
        chk("flush calc no_ready", 32'(pulses), 32'd0);
        chk("flush calc result", result, held);
        run_op("divu max/1", 3'b101, 32'hFFFF_FFFF, 32'd1);

        // Flush while in FIXUP: the result register must not be written
        held = result;
        launch(3'b101, 32'd77, 32'd5);
        repeat (32) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush fixup idle", 32'(busy), 32'd0);
        count_pulses(5, pulses);
        chk("flush fixup no_ready", 32'(pulses), 32'd0);
        chk("flush fixup result", result, held);

        // flush and start together: request dropped
        @(negedge clk);
        start = 1'b1;
        flush = 1'b1;
        div_ctrl = 3'b101;
        op1 = 32'd9;
        op2 = 32'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        chk("flush+start busy", 32'(busy), 32'd0);
        chk("flush+start ready", 32'(div_ready), 32'd0);

        // start while busy must be ignored
        launch(3'b101, 32'd100, 32'd7);
        repeat (4) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        div_ctrl = 3'b101;
        op1 = 32'd50;
        op2 = 32'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_ready(lat);
        chk("start busy latency", 32'(lat + 5), 32'd34);
        chk("start busy result", result, 32'd14);
        @(posedge clk);
        #1;
        chk("start busy idle", 32'(busy), 32'd0);

        // Asynchronous reset mid-CALC
        launch(3'b101, 32'd100, 32'd7);
        repeat (5) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst busy", 32'(busy), 32'd0);
        chk("async rst ready", 32'(div_ready), 32'd0);
        chk("async rst result", result, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        count_pulses(40, pulses);
        chk("async rst no_ready", 32'(pulses), 32'd0);

        for (int i = 0; i < 40; i++) begin
            c = 3'(4 + $urandom_range(0, 3));
            a = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'h0;
                1: b = 32'($urandom_range(1, 15));
                2: b = 32'hFFFF_FFFF;
                3: begin
                    a = 32'h8000_0000;
                    b = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : $urandom;
                end
                4: b = $urandom >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            run_op($sformatf("rand%0d c=%0d a=%08h b=%08h", i, c, a, b), c, a, b);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/div_iter.md
Name: div_iter

Overview:
- Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
- Sits in the execute stage beside the single-cycle ALU and multiplier.
- Responds to a start request from the pipeline and returns a registered result with a one-cycle div_ready pulse, which the hazard unit uses to release the execute-stage stall.
- Replaces the combinational divider on the timing-critical path.

Parameters:
- DATA_WIDTH, 32, operand/result width; iteration count equals DATA_WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- div_ctrl  input  3  func3: 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op1  input  DATA_WIDTH  dividend (rs1)
- op2  input  DATA_WIDTH  divisor (rs2)
- flush  input  1  abort in-flight operation (branch mispredict/trap)
- result  output  DATA_WIDTH  quotient or remainder per div_ctrl[1]
- busy  output  1  high in CALC, FIXUP and DONE; pipeline stalls on busy or start
- div_ready  output  1  one-cycle pulse; result valid in the same cycle

Behaviour:
- Reset: one clock, asynchronous, active-low. While rst_n is low: state IDLE, result 0, busy 0, div_ready 0, all internal registers 0. Asserting reset mid-operation discards that operation without a div_ready pulse.
- States: IDLE, CALC, FIXUP, DONE.
- IDLE, start=1 at edge E0, normal case:
  - Latch div_ctrl.
  - Latch absolute values of op1/op2 when signed (div_ctrl[0]=0), raw values otherwise.
  - Latch quotient sign (op1[31]^op2[31]) and remainder sign (op1[31]).
  - Clear partial remainder; load iteration counter with DATA_WIDTH-1; go to CALC.
- IDLE, start=1 at E0, special cases (go directly to DONE, div_ready high in the cycle after E0):
  - op2==0: quotient = all ones; remainder = op1.
  - Signed overflow (DIV/REM, op1=0x80000000, op2=0xFFFFFFFF): quotient = 0x80000000; remainder = 0.
- CALC, one quotient bit per cycle, MSB first:
  - Shift {rem, dividend} left by 1.
  - Trial subtract divisor from rem, a DATA_WIDTH+1-bit subtraction so the borrow is explicit.
  - No borrow: keep the difference and set quotient bit = 1. Borrow: restore rem and set quotient bit = 0.
  - Counter decrements each cycle. After the counter==0 iteration (edge E32), go to FIXUP.
- FIXUP (edge E33):
  - Negate the quotient if the operation is signed and the quotient sign is 1.
  - Negate the remainder if the operation is signed and the remainder sign is 1.
  - Select quotient (div_ctrl[1]=0) or remainder (div_ctrl[1]=1) into the result register; go to DONE.
- DONE:
  - div_ready=1 for exactly this cycle; the result register is valid.
  - The next edge returns unconditionally to IDLE.
  - start is not sampled in DONE.
- Latency, normal case: start edge E0 to div_ready cycle following E33, i.e. 34 cycles.
- Latency, special case: 1 cycle.
- result holds its value after DONE until the next operation writes it. The register is not cleared on return to IDLE.
- busy is combinational from state: 1 in CALC, FIXUP and DONE; 0 in IDLE.
- start while not IDLE: ignored. Operands are not re-sampled mid-operation.
- flush:
  - In CALC or FIXUP: go to IDLE at the next edge; no div_ready pulse; result unchanged.
  - In DONE: the pulse still occurs this cycle (the instruction already completed).
  - flush and start together in IDLE: flush wins; the request is not accepted.
- Signed result is the truncated (round-toward-zero) quotient; the remainder takes the sign of the dividend, per RISC-V.

Test Plan:
- DIVU op1=100, op2=7 -> div_ready exactly 34 cycles after start; result=14 (0x0000000E). Repeat as REMU -> result=2.
- DIV op1=0xFFFFFFF9 (-7), op2=2 -> result=0xFFFFFFFD (-3). REM with the same operands -> 0xFFFFFFFF (-1). REM with op1=7, op2=0xFFFFFFFE -> 1.
- Divide by zero:
  - DIV 5/0 -> 0xFFFFFFFF.
  - REMU 5/0 -> 5.
  - Both with div_ready in the cycle after start and busy high only during that DONE cycle.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0. Both with 1-cycle latency.
- Abort and back-to-back:
  - Assert flush in cycle 10 of CALC -> state IDLE next cycle, no div_ready, result unchanged.
  - Then start DIVU 0xFFFFFFFF / 1 -> result 0xFFFFFFFF after 34 cycles.
- Reset and start-while-busy:
  - Pull rst_n low mid-CALC -> busy, div_ready and result go to 0 immediately (asynchronously).
  - Pulse start while busy with different operands -> ignored; the original result is returned.
